// File: rtl/inp_port_if.sv
// inp_port_if: switch/button input port bundle.
//   inp     raw switch levels (asynchronous to clock)
//   btn     raw enter button, active-high, bouncy
//   rd      one-cycle read strobe from the processor IN instruction
//   inval   holding register contents
//   valid   holding register contains an unread word
//   overrun sticky: a press overwrote an unread word
//   live    debounced current switch value
// master: board/processor side, slave: inp_port.
interface inp_port_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] inp;
  logic             btn;
  logic             rd;
  logic [WIDTH-1:0] inval;
  logic             valid;
  logic             overrun;
  logic [WIDTH-1:0] live;

  modport master (
    output inp, btn, rd,
    input  inval, valid, overrun, live
  );

  modport slave (
    input  inp, btn, rd,
    output inval, valid, overrun, live
  );
endinterface

// File: rtl/inp_port.sv
// inp_port: processor IN path from board switches and an enter button.
// Synchronizes and debounces the switch bus and the button, latches the
// debounced switch word on each button press into a one-entry holding
// register and hands it over with a valid/rd handshake.
// Ports:
//   clock    system clock, all logic on posedge
//   n_reset  asynchronous active-low reset
//   bus      inp_port_if.slave (inp, btn, rd in; inval, valid, overrun, live out)
//
// Holding FSM:
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | no unread word, valid=0
//   ST_FULL  | inval holds an unread word, valid=1
module inp_port #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 50000,
  parameter int CNT_W    = 16
) (
  input logic        clock,
  input logic        n_reset,
  inp_port_if.slave  bus
);

  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_FULL  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // two-flop synchronizers
  logic [WIDTH-1:0] inp_m_q, s_inp_q;
  logic             btn_m_q, s_btn_q;

  // switch debounce
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [WIDTH-1:0] live_q, live_d;

  // button debounce and edge detect
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_prev_q;
  logic             btn_edge;

  // holding register
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] inval_q, inval_d;
  logic             ovr_q, ovr_d;

  // A new level is accepted only after DEBOUNCE consecutive cycles of
  // disagreement with the current level; any return to it restarts.
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    live_d   = live_q;
    if (s_inp_q == live_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == CNT_MAX) begin
      live_d   = s_inp_q;
      sw_cnt_d = '0;
    end else begin
      sw_cnt_d = sw_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    btn_cnt_d = btn_cnt_q;
    btn_db_d  = btn_db_q;
    if (s_btn_q == btn_db_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q == CNT_MAX) begin
      btn_db_d  = s_btn_q;
      btn_cnt_d = '0;
    end else begin
      btn_cnt_d = btn_cnt_q + CNT_ONE;
    end
  end

  // High for exactly the one cycle after btn_db rises.
  assign btn_edge = btn_db_q & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    inval_d = inval_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_EMPTY: begin
        if (btn_edge) begin
          inval_d = live_q;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (btn_edge) begin
          // A same-cycle read consumed the old word, so no overrun then.
          inval_d = live_q;
          ovr_d   = ~bus.rd;
        end else if (bus.rd) begin
          state_d = ST_EMPTY;
          ovr_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      inp_m_q    <= '0;
      s_inp_q    <= '0;
      btn_m_q    <= 1'b0;
      s_btn_q    <= 1'b0;
      sw_cnt_q   <= '0;
      live_q     <= '0;
      btn_cnt_q  <= '0;
      btn_db_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      state_q    <= ST_EMPTY;
      inval_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      inp_m_q    <= bus.inp;
      s_inp_q    <= inp_m_q;
      btn_m_q    <= bus.btn;
      s_btn_q    <= btn_m_q;
      sw_cnt_q   <= sw_cnt_d;
      live_q     <= live_d;
      btn_cnt_q  <= btn_cnt_d;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      state_q    <= state_d;
      inval_q    <= inval_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.inval   = inval_q;
  assign bus.valid   = (state_q == ST_FULL);
  assign bus.overrun = ovr_q;
  assign bus.live    = live_q;

endmodule

// File: tb/tb_inp_port.sv
// tb_inp_port: directed bench for inp_port with DEBOUNCE=4.
// A clean raw change first seen at edge N reaches live at edge N+5; a clean
// button press captures one edge after btn_db rises.
module tb_inp_port;

  logic clock;
  logic n_reset;
  int   checks;
  int   errors;

  inp_port_if #(.WIDTH(16)) bus ();

  inp_port #(
    .WIDTH(16),
    .DEBOUNCE(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .n_reset(n_reset),
    .bus(bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_pulse();
    bus.rd = 1'b1;
    ticks(1);
    bus.rd = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    n_reset    = 1'b0;
    bus.inp    = 16'hFFFF;
    bus.btn    = 1'b1;
    bus.rd     = 1'b0;

    // 1. reset, then rebuild live and capture from the held button
    #3;
    ticks(3);
    check("rst_live",    32'(bus.live),    32'h0);
    check("rst_inval",   32'(bus.inval),   32'h0);
    check("rst_valid",   32'(bus.valid),   32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    #2 n_reset = 1'b1;
    ticks(5);
    check("rel_live_e5", 32'(bus.live), 32'h0);
    ticks(1);
    check("rel_live_e6",  32'(bus.live),  32'hFFFF);
    check("rel_valid_e6", 32'(bus.valid), 32'h0);
    ticks(1);
    check("rel_valid_e7", 32'(bus.valid), 32'h1);
    check("rel_inval_e7", 32'(bus.inval), 32'hFFFF);
    bus.btn = 1'b0;
    ticks(8);
    rd_pulse();
    check("rel_rd_valid", 32'(bus.valid), 32'h0);

    // 2. glitch shorter than the debounce window is rejected
    bus.inp = 16'h0000;
    ticks(8);
    check("db_base", 32'(bus.live), 32'h0);
    bus.inp = 16'h1234;
    ticks(3);
    bus.inp = 16'h0000;
    ticks(1);
    bus.inp = 16'h1234;
    ticks(5);
    check("db_glitch_e9", 32'(bus.live), 32'h0);
    ticks(1);
    check("db_clean_e10", 32'(bus.live), 32'h1234);

    // 3. bouncy press gives one capture; rd empties and keeps inval
    bus.inp = 16'hBEEF;
    ticks(8);
    check("hs_live", 32'(bus.live), 32'hBEEF);
    bus.btn = 1'b1; ticks(1);
    bus.btn = 1'b0; ticks(1);
    bus.btn = 1'b1; ticks(1);
    bus.btn = 1'b0; ticks(1);
    bus.btn = 1'b1;
    ticks(6);
    check("hs_valid_e10", 32'(bus.valid), 32'h0);
    ticks(1);
    check("hs_valid_e11", 32'(bus.valid), 32'h1);
    check("hs_inval",     32'(bus.inval), 32'hBEEF);
    ticks(4);
    bus.btn = 1'b0;
    ticks(8);
    check("hs_hold_ovr",   32'(bus.overrun), 32'h0);
    check("hs_hold_valid", 32'(bus.valid),   32'h1);
    rd_pulse();
    check("hs_rd_valid", 32'(bus.valid), 32'h0);
    check("hs_rd_inval", 32'(bus.inval), 32'hBEEF);
    ticks(2);
    check("hs_empty_rd_valid", 32'(bus.valid), 32'h0);

    // 4. overrun
    bus.inp = 16'h0001; ticks(8);
    bus.btn = 1'b1;     ticks(8);
    bus.btn = 1'b0;     ticks(8);
    check("ov_first_inval", 32'(bus.inval),   32'h0001);
    check("ov_first_ovr",   32'(bus.overrun), 32'h0);
    bus.inp = 16'h0002; ticks(8);
    bus.btn = 1'b1;     ticks(8);
    check("ov_inval", 32'(bus.inval),   32'h0002);
    check("ov_valid", 32'(bus.valid),   32'h1);
    check("ov_ovr",   32'(bus.overrun), 32'h1);
    bus.btn = 1'b0;     ticks(8);
    rd_pulse();
    check("ov_rd_valid", 32'(bus.valid),   32'h0);
    check("ov_rd_ovr",   32'(bus.overrun), 32'h0);

    // 5. rd on the same edge as a capture
    bus.inp = 16'h00AA; ticks(8);
    bus.btn = 1'b1;     ticks(8);
    bus.btn = 1'b0;     ticks(8);
    check("sim_pre_inval", 32'(bus.inval), 32'h00AA);
    bus.inp = 16'h0055; ticks(8);
    bus.btn = 1'b1;
    ticks(6);
    check("sim_e6_inval", 32'(bus.inval), 32'h00AA);
    rd_pulse();
    check("sim_inval", 32'(bus.inval),   32'h0055);
    check("sim_valid", 32'(bus.valid),   32'h1);
    check("sim_ovr",   32'(bus.overrun), 32'h0);
    bus.btn = 1'b0; ticks(8);

    // 6. asynchronous reset mid-operation
    bus.inp = 16'h0066; ticks(8);
    bus.btn = 1'b1;     ticks(8);
    check("mr_pre_ovr", 32'(bus.overrun), 32'h1);
    bus.inp = 16'h0077;
    ticks(3);
    #2 n_reset = 1'b0;
    #1;
    check("mr_valid", 32'(bus.valid),   32'h0);
    check("mr_ovr",   32'(bus.overrun), 32'h0);
    check("mr_inval", 32'(bus.inval),   32'h0);
    check("mr_live",  32'(bus.live),    32'h0);
    #1 n_reset = 1'b1;
    ticks(5);
    check("mr_live_e5", 32'(bus.live), 32'h0);
    ticks(1);
    check("mr_live_e6", 32'(bus.live), 32'h0077);
    ticks(1);
    check("mr_valid_e7", 32'(bus.valid), 32'h1);
    check("mr_inval_e7", 32'(bus.inval), 32'h0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inp_port.md
Name: inp_port

Overview:
- Input-side counterpart of the LED/7-seg output driver: the processor's IN path from board switches and an enter button.
- Synchronizes and debounces 16 raw switches plus one enter button.
- On each debounced button press, latches the switch word into a one-entry holding register.
- Hands the word to the processor through a valid/rd handshake, flagging overrun when a press overwrites an unread word.

Parameters:
WIDTH, 16, switch bus and data width.
DEBOUNCE, 50000, consecutive stable cycles required to accept a new level (minimum 2).
CNT_W, 16, debounce counter width; must hold DEBOUNCE-1.

Ports:
clock  input  1  system clock, all logic on posedge.
n_reset  input  1  asynchronous, active-low reset.
inp  input  WIDTH  raw switch levels, asynchronous to clock.
btn  input  1  raw enter button, active-high, asynchronous, bouncy.
rd  input  1  one-cycle read strobe from processor IN instruction.
inval  output  WIDTH  holding register contents.
valid  output  1  holding register contains an unread word.
overrun  output  1  sticky: a press overwrote an unread word.
live  output  WIDTH  debounced current switch value, for display.

Behaviour:
- Reset: one clock, asynchronous, active-low; polarity and synchronicity are fixed.
  - While n_reset=0, all flops clear asynchronously: synchronizers, counters, live=0, inval=0, valid=0, overrun=0, state=EMPTY.
  - Deassertion is used directly; no internal reset synchronizer.
- Synchronizer: two flops per bit on inp and btn. Outputs are s_inp and s_btn.
- Switch debounce: one bus-wide counter sw_cnt.
  - If s_inp==live, sw_cnt<=0.
  - Else, if sw_cnt==DEBOUNCE-1: live<=s_inp and sw_cnt<=0. Otherwise sw_cnt<=sw_cnt+1.
  - Any glitch back to live restarts the count.
  - Latency from a clean raw change to live updating: DEBOUNCE+2 cycles.
- Button debounce: identical logic with its own counter, producing btn_db.
  - btn_edge is a one-cycle pulse on the rising edge of btn_db, registered against the previous btn_db.
  - A held button produces exactly one pulse. Release produces none.
- Holding FSM, states EMPTY and FULL; valid = (state==FULL).
  - EMPTY, btn_edge: inval<=live; go to FULL.
  - EMPTY, rd: ignored; inval, valid and overrun unchanged.
  - FULL, rd without btn_edge: go to EMPTY; overrun<=0. inval keeps its last value.
  - FULL, btn_edge without rd: inval<=live; stay FULL; overrun<=1.
  - FULL, rd and btn_edge in the same cycle: inval<=live; stay FULL; overrun<=0. The read consumed the old word, so there is no overrun.
- Capture uses live as registered on the btn_edge cycle. A switch change still inside its debounce window is not captured.
- rd is sampled on the same edge as btn_edge. The processor samples inval on the rd cycle, before the edge.
- Counter arithmetic is unsigned CNT_W-bit and never wraps: it is bounded by DEBOUNCE-1.
- Reset mid-debounce or mid-handshake discards everything. After release, live rebuilds from 0 via a normal debounce, so the first update takes DEBOUNCE+2 cycles.

Test Plan:
All tests use DEBOUNCE=4.
1. Reset: hold n_reset=0 with inp=16'hFFFF and btn=1 -> all outputs 0 during reset. Release with inp=16'hFFFF held -> live=16'hFFFF exactly 6 cycles after release; valid rises once btn_db completes its own debounce.
2. Debounce: inp toggles 16'h0000→16'h1234 for 3 cycles, back for 1, then 16'h1234 steady -> live stays 16'h0000 through the glitch, becomes 16'h1234 DEBOUNCE+2 cycles after the final clean edge.
3. Handshake: live=16'hBEEF, btn bounces 1-0-1-0-1 then held high -> exactly one capture, inval=16'hBEEF, valid=1. rd pulse -> valid=0 next cycle, inval stays 16'hBEEF.
4. Overrun: capture 16'h0001, no rd, change switches to 16'h0002 and press again -> inval=16'h0002, valid=1, overrun=1. rd -> valid=0, overrun=0.
5. Simultaneous: state FULL with 16'h00AA, rd asserted on the same edge as a btn_edge capturing 16'h0055 -> inval=16'h0055, valid=1, overrun=0.
6. Reset mid-operation: FULL with overrun=1 and a debounce count in flight; pulse n_reset low asynchronously, between clock edges -> immediately valid=0, overrun=0, inval=0, live=0.
